csr_timer_stack: RTL and testbench

// - Support block for the n_clic interrupt controller. Bundles three functions:
//   - a generic width-parameterised CSR with Zicsr ops, external hardware write and VCSR bit-field access;
//   - a timer CSR that raises a periodic interrupt request;
//   - an interrupt-return stack of {epc, prio} entries that reports its depth.
// - Sits beside the decoder/CSR path; n_clic instantiates it per its thresholds, vectors and epc stack.

---
 rtl/csr_timer_stack_pkg.sv | 43 ++++
 rtl/csr_timer_stack_csr_field.sv | 71 +++++++
 rtl/csr_timer_stack.sv | 179 +++++++++++++++++
 tb/tb_csr_timer_stack.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_timer_stack_pkg.sv
// Shared types, widths and CSR address map for the n_clic support block.
package csr_timer_stack_pkg;

    localparam int unsigned PrioWidth     = 3;
    localparam int unsigned IMemAddrWidth = 16;

    typedef logic [11:0]              CsrAddrT;
    typedef logic [31:0]              word;
    typedef logic [4:0]               r;
    typedef logic [4:0]               vcsr_width_t;
    typedef logic [4:0]               vcsr_offset_t;
    typedef logic [31:0]              TimerT;
    typedef logic [PrioWidth-1:0]     PrioT;
    typedef logic [IMemAddrWidth-1:0] IMemAddrT;

    // Zicsr funct3 encodings.
    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_op_t;

    localparam CsrAddrT MIntThreshAddr = 12'h347;
    localparam CsrAddrT MTimerAddr     = 12'h400;
    localparam CsrAddrT StackDepthAddr = 12'h350;

    function automatic logic is_imm_op(csr_op_t op);
        return op inside {CSRRWI, CSRRSI, CSRRCI};
    endfunction

    function automatic logic is_set_clear_op(csr_op_t op);
        return op inside {CSRRS, CSRRC, CSRRSI, CSRRCI};
    endfunction

    // Field of (w+1) bits at offset o; a 32-bit field shifts 1 out to 0, so minus 1 gives all ones.
    function automatic word field_mask(vcsr_width_t w, vcsr_offset_t o);
        return ((word'(1) << (32'(w) + 32'd1)) - word'(1)) << o;
    endfunction

endpackage

// File: rtl/csr_timer_stack_csr_field.sv
// Generic CSR register: Zicsr ops, VCSR bit-field access and a hardware write port.
module csr_field
    import csr_timer_stack_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter CsrAddrT     Addr  = MIntThreshAddr
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              csr_enable,
    input  CsrAddrT           csr_addr,
    input  csr_op_t           csr_op,
    input  r                  rs1_zimm,
    input  word               rs1_data,
    input  CsrAddrT           vcsr_addr,
    input  vcsr_width_t       vcsr_width,
    input  vcsr_offset_t      vcsr_offset,
    input  logic [Width-1:0]  ext_data,
    input  logic              ext_write_enable,
    output logic [Width-1:0]  data,
    output word               field_data,
    output logic              vcsr_hit,
    output logic              written
);

    word              old_word;
    word              operand;
    word              mask;
    logic [Width-1:0] mask_w;
    logic [Width-1:0] opnd_w;
    logic [Width-1:0] next_value;
    logic             direct_hit;
    logic             op_valid;

    // Direct access uses an all-ones mask at offset 0, so one datapath serves both access kinds.
    always_comb begin
        old_word             = '0;
        old_word[Width-1:0]  = data;
        direct_hit           = csr_enable && (csr_addr == Addr);
        vcsr_hit             = csr_enable && (vcsr_addr == Addr) && (csr_addr != Addr);
        operand              = is_imm_op(csr_op) ? word'(rs1_zimm) : rs1_data;
        mask                 = vcsr_hit ? field_mask(vcsr_width, vcsr_offset) : '1;
        mask_w               = Width'(mask);
        opnd_w               = Width'(vcsr_hit ? (operand << vcsr_offset) : operand);
        field_data           = (old_word & mask) >> vcsr_offset;
        op_valid             = 1'b1;
        case (csr_op)
            CSRRW, CSRRWI: next_value = (data & ~mask_w) | (opnd_w & mask_w);
            CSRRS, CSRRSI: next_value = data | (opnd_w & mask_w);
            CSRRC, CSRRCI: next_value = data & ~(opnd_w & mask_w);
            default: begin
                next_value = data;
                op_valid   = 1'b0;
            end
        endcase
        written = (direct_hit || vcsr_hit) && op_valid && !ext_write_enable
                  && !(is_set_clear_op(csr_op) && (operand == '0));
    end

    // Hardware write takes precedence over the instruction path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
        end else if (ext_write_enable) begin
            data <= ext_data;
        end else if (written) begin
            data <= next_value;
        end
    end

endmodule

// File: rtl/csr_timer_stack.sv
// n_clic support block: generic CSR, periodic timer CSR and interrupt-return stack.
// StackDepth must be at least 2; CsrWidth in 1..32.
module csr_timer_stack
    import csr_timer_stack_pkg::*;
#(
    parameter int unsigned CsrWidth   = PrioWidth,
    parameter CsrAddrT     Addr       = MIntThreshAddr,
    parameter CsrAddrT     TimerAddr  = MTimerAddr,
    parameter int unsigned StackDepth = 8,
    parameter int unsigned DataWidth  = IMemAddrWidth + PrioWidth
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            csr_enable,
    input  CsrAddrT                         csr_addr,
    input  csr_op_t                         csr_op,
    input  r                                rs1_zimm,
    input  word                             rs1_data,
    input  CsrAddrT                         vcsr_addr,
    input  vcsr_width_t                     vcsr_width,
    input  vcsr_offset_t                    vcsr_offset,
    input  logic [CsrWidth-1:0]             ext_data,
    input  logic                            ext_write_enable,
    input  logic                            interrupt_clear,
    input  logic                            push,
    input  logic                            pop,
    input  logic [DataWidth-1:0]            stack_in,
    output logic [CsrWidth-1:0]             data,
    output logic                            interrupt_set,
    output logic [DataWidth-1:0]            stack_out,
    output logic [$clog2(StackDepth+1)-1:0] index_out,
    output word                             csr_out
);

    localparam int unsigned IdxWidth = $clog2(StackDepth + 1);
    localparam int unsigned PtrWidth = $clog2(StackDepth);

    word   gen_field;
    logic  gen_vcsr_hit;
    logic  gen_written_unused;
    TimerT timer;
    word   timer_field;
    logic  timer_vcsr_hit;
    logic  timer_written;

    csr_field #(.Width(CsrWidth), .Addr(Addr)) u_generic (
        .clk              (clk),
        .reset            (reset),
        .csr_enable       (csr_enable),
        .csr_addr         (csr_addr),
        .csr_op           (csr_op),
        .rs1_zimm         (rs1_zimm),
        .rs1_data         (rs1_data),
        .vcsr_addr        (vcsr_addr),
        .vcsr_width       (vcsr_width),
        .vcsr_offset      (vcsr_offset),
        .ext_data         (ext_data),
        .ext_write_enable (ext_write_enable),
        .data             (data),
        .field_data       (gen_field),
        .vcsr_hit         (gen_vcsr_hit),
        .written          (gen_written_unused)
    );

    csr_field #(.Width(32), .Addr(TimerAddr)) u_timer (
        .clk              (clk),
        .reset            (reset),
        .csr_enable       (csr_enable),
        .csr_addr         (csr_addr),
        .csr_op           (csr_op),
        .rs1_zimm         (rs1_zimm),
        .rs1_data         (rs1_data),
        .vcsr_addr        (vcsr_addr),
        .vcsr_width       (vcsr_width),
        .vcsr_offset      (vcsr_offset),
        .ext_data         ('0),
        .ext_write_enable (1'b0),
        .data             (timer),
        .field_data       (timer_field),
        .vcsr_hit         (timer_vcsr_hit),
        .written          (timer_written)
    );

    logic [3:0]  prescale;
    logic [27:0] compare;
    logic [15:0] presc_cnt;
    logic [15:0] presc_limit;
    logic [27:0] count;
    logic        tick;
    logic        match;

    // Decode the timer fields and detect a compare hit on a prescaled tick.
    always_comb begin
        prescale    = timer[31:28];
        compare     = timer[27:0];
        presc_limit = (16'd1 << prescale) - 16'd1;
        tick        = (presc_cnt == presc_limit);
        match       = !timer_written && (compare != '0) && tick && (count == compare);
    end

    // Prescaled free-running counter; a timer write or a zero compare restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt <= '0;
            count     <= '0;
        end else if (timer_written || (compare == '0)) begin
            presc_cnt <= '0;
            count     <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
            count     <= match ? '0 : count + 28'd1;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end

    // A match sets the request; acknowledge clears it only when no match coincides.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            interrupt_set <= 1'b0;
        end else if (match) begin
            interrupt_set <= 1'b1;
        end else if (interrupt_clear) begin
            interrupt_set <= 1'b0;
        end
    end

    logic [DataWidth-1:0] entries [StackDepth];
    logic [IdxWidth-1:0]  depth;
    logic [PtrWidth-1:0]  top_ptr;
    logic [PtrWidth-1:0]  push_ptr;
    logic                 do_push;
    logic                 do_pop;

    // Qualify strobes; push+pop on a full stack still replaces the top.
    always_comb begin
        do_pop    = pop && (depth != '0);
        do_push   = push && ((depth != IdxWidth'(StackDepth)) || do_pop);
        top_ptr   = PtrWidth'(depth - 1'b1);
        push_ptr  = PtrWidth'(depth);
        stack_out = (depth == '0) ? '0 : entries[top_ptr];
        index_out = depth;
    end

    // Stack storage and depth pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth <= '0;
            for (int unsigned i = 0; i < StackDepth; i++) begin
                entries[i] <= '0;
            end
        end else if (do_push && do_pop) begin
            entries[top_ptr] <= stack_in;
        end else if (do_push) begin
            entries[push_ptr] <= stack_in;
            depth             <= depth + 1'b1;
        end else if (do_pop) begin
            depth <= depth - 1'b1;
        end
    end

    // Read mux: direct addresses first, then a VCSR field view.
    always_comb begin
        if (csr_addr == Addr) begin
            csr_out = word'(data);
        end else if (csr_addr == TimerAddr) begin
            csr_out = timer;
        end else if (csr_addr == StackDepthAddr) begin
            csr_out = word'(index_out);
        end else if (gen_vcsr_hit) begin
            csr_out = gen_field;
        end else if (timer_vcsr_hit) begin
            csr_out = timer_field;
        end else begin
            csr_out = '0;
        end
    end

endmodule

// File: tb/tb_csr_timer_stack.sv
// Randomized bench for csr_timer_stack with a behavioural reference model.
module tb_csr_timer_stack;
    import csr_timer_stack_pkg::*;

    localparam int unsigned CW = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned DW = 19;
    localparam int unsigned IW = $clog2(D + 1);
    localparam CsrAddrT ADDR  = MIntThreshAddr;
    localparam CsrAddrT TADDR = MTimerAddr;
    localparam CsrAddrT SADDR = StackDepthAddr;
    localparam CsrAddrT NADDR = 12'h001;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          csr_enable = 1'b0;
    CsrAddrT       csr_addr = NADDR;
    csr_op_t       csr_op = CSRRW;
    r              rs1_zimm = '0;
    word           rs1_data = '0;
    CsrAddrT       vcsr_addr = NADDR;
    vcsr_width_t   vcsr_width = '0;
    vcsr_offset_t  vcsr_offset = '0;
    logic [CW-1:0] ext_data = '0;
    logic          ext_write_enable = 1'b0;
    logic          interrupt_clear = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] stack_in = '0;
    logic [CW-1:0] data;
    logic          interrupt_set;
    logic [DW-1:0] stack_out;
    logic [IW-1:0] index_out;
    word           csr_out;

    int checks = 0;
    int errors = 0;

    csr_op_t ops [6] = '{CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI};

    csr_timer_stack #(
        .CsrWidth   (CW),
        .Addr       (ADDR),
        .TimerAddr  (TADDR),
        .StackDepth (D),
        .DataWidth  (DW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .csr_enable       (csr_enable),
        .csr_addr         (csr_addr),
        .csr_op           (csr_op),
        .rs1_zimm         (rs1_zimm),
        .rs1_data         (rs1_data),
        .vcsr_addr        (vcsr_addr),
        .vcsr_width       (vcsr_width),
        .vcsr_offset      (vcsr_offset),
        .ext_data         (ext_data),
        .ext_write_enable (ext_write_enable),
        .interrupt_clear  (interrupt_clear),
        .push             (push),
        .pop              (pop),
        .stack_in         (stack_in),
        .data             (data),
        .interrupt_set    (interrupt_set),
        .stack_out        (stack_out),
        .index_out        (index_out),
        .csr_out          (csr_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned       m_data  = 0;
    int unsigned       m_timer = 0;
    longint unsigned   m_phase = 0;
    bit                m_irq   = 0;
    logic [DW-1:0]     m_stack [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned fmask(int unsigned w, int unsigned off);
        int unsigned m = 0;
        for (int unsigned b = 0; b <= w; b++) begin
            if (off + b < 32) m |= (32'd1 << (off + b));
        end
        return m;
    endfunction

    function automatic int unsigned apply_op(int unsigned old, csr_op_t op, int unsigned src, int unsigned mask);
        case (op)
            CSRRW, CSRRWI: return (old & ~mask) | (src & mask);
            CSRRS, CSRRSI: return old | (src & mask);
            default:       return old & ~(src & mask);
        endcase
    endfunction

    // Evaluates the current instruction against one register: returns whether it writes.
    function automatic bit reg_access(input CsrAddrT a, input int unsigned old, input int unsigned width,
                                      output int unsigned nv, output int unsigned rd);
        bit direct, vc, imm, sc;
        int unsigned opnd, mask, off;
        direct = csr_enable && (csr_addr == a);
        vc     = csr_enable && (vcsr_addr == a) && (csr_addr != a);
        imm    = (csr_op == CSRRWI) || (csr_op == CSRRSI) || (csr_op == CSRRCI);
        sc     = (csr_op != CSRRW) && (csr_op != CSRRWI);
        opnd   = imm ? int'(rs1_zimm) : rs1_data;
        mask   = vc ? fmask(vcsr_width, vcsr_offset) : 32'hFFFF_FFFF;
        off    = vc ? int'(vcsr_offset) : 0;
        rd     = (old & mask) >> off;
        nv     = apply_op(old, csr_op, opnd << off, mask);
        if (width < 32) nv = nv % (32'd1 << width);
        return (direct || vc) && !(sc && opnd == 0);
    endfunction

    function automatic int unsigned exp_csr_out();
        int unsigned nv, rd;
        if (csr_addr == ADDR)  return m_data;
        if (csr_addr == TADDR) return m_timer;
        if (csr_addr == SADDR) return m_stack.size();
        if (csr_enable && vcsr_addr == ADDR) begin
            void'(reg_access(ADDR, m_data, CW, nv, rd));
            return rd;
        end
        if (csr_enable && vcsr_addr == TADDR) begin
            void'(reg_access(TADDR, m_timer, 32, nv, rd));
            return rd;
        end
        return 0;
    endfunction

    always @(negedge reset) begin
        m_data  = 0;
        m_timer = 0;
        m_phase = 0;
        m_irq   = 0;
        m_stack.delete();
    end

    always @(posedge clk) begin
        if (reset) begin
            int unsigned nv_g, nv_t, rd, c, p;
            bit wg, wt, hit, dp, du;
            wg  = reg_access(ADDR, m_data, CW, nv_g, rd);
            wt  = reg_access(TADDR, m_timer, 32, nv_t, rd);
            c   = m_timer % 32'h1000_0000;
            p   = m_timer / 32'h1000_0000;
            hit = 0;
            if (wt || c == 0) begin
                m_phase = 0;
            end else begin
                m_phase++;
                if (m_phase == ((longint'(c) + 1) * (longint'(1) << p))) begin
                    m_phase = 0;
                    hit     = 1;
                end
            end
            if (hit) m_irq = 1;
            else if (interrupt_clear) m_irq = 0;
            if (ext_write_enable) m_data = ext_data;
            else if (wg) m_data = nv_g;
            if (wt) m_timer = nv_t;
            dp = pop && (m_stack.size() > 0);
            du = push && ((m_stack.size() < D) || dp);
            if (du && dp) m_stack[m_stack.size() - 1] = stack_in;
            else if (du) m_stack.push_back(stack_in);
            else if (dp) void'(m_stack.pop_back());
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("data", data, m_data);
        chk("interrupt_set", interrupt_set, m_irq);
        chk("index_out", index_out, m_stack.size());
        chk("stack_out", stack_out, (m_stack.size() > 0) ? m_stack[$] : '0);
        chk("csr_out", csr_out, exp_csr_out());
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
        csr_enable       = 1'b0;
        ext_write_enable = 1'b0;
        interrupt_clear  = 1'b0;
        push             = 1'b0;
        pop              = 1'b0;
    endtask

    task automatic instr(input CsrAddrT a, input csr_op_t op, input word d, input r z);
        csr_enable = 1'b1;
        csr_addr   = a;
        vcsr_addr  = NADDR;
        csr_op     = op;
        rs1_data   = d;
        rs1_zimm   = z;
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (!interrupt_set && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic stack_op(input logic pu, input logic po, input logic [DW-1:0] v);
        push     = pu;
        pop      = po;
        stack_in = v;
        step();
    endtask

    task automatic rand_inputs();
        CsrAddrT picks [4];
        picks            = '{ADDR, TADDR, SADDR, CsrAddrT'($urandom)};
        csr_enable       = ($urandom_range(0, 4) == 0);
        csr_addr         = picks[$urandom_range(0, 3)];
        vcsr_addr        = picks[$urandom_range(0, 3)];
        csr_op           = ops[$urandom_range(0, 5)];
        rs1_zimm         = r'($urandom);
        vcsr_width       = vcsr_width_t'($urandom);
        vcsr_offset      = vcsr_offset_t'($urandom);
        case ($urandom_range(0, 3))
            0:       rs1_data = '0;
            1:       rs1_data = $urandom;
            default: rs1_data = (word'($urandom_range(0, 2)) << 28) | word'($urandom_range(0, 9));
        endcase
        ext_write_enable = ($urandom_range(0, 7) == 0);
        ext_data         = CW'($urandom);
        interrupt_clear  = ($urandom_range(0, 3) == 0);
        push             = ($urandom_range(0, 2) == 0);
        pop              = ($urandom_range(0, 2) == 0);
        stack_in         = DW'($urandom);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_data", data, 0);
        chk("reset_irq", interrupt_set, 0);
        chk("reset_index", index_out, 0);
        chk("reset_stack_out", stack_out, 0);
        reset = 1'b1;
        step();

        // Zicsr ops on the generic CSR
        instr(ADDR, CSRRW, 32'h2, '0);
        step();
        chk("rw_seed", data, 8'h2);
        instr(ADDR, CSRRS, 32'h5, '0);
        #1 chk("rs_read_old", csr_out, 32'h2);
        step();
        chk("rs_result", data, 8'h7);
        instr(ADDR, CSRRCI, '0, 5'h1);
        step();
        chk("rci_result", data, 8'h6);
        instr(ADDR, CSRRS, '0, '0);
        step();
        chk("rs_zero_no_write", data, 8'h6);
        instr(ADDR, CSRRW, '0, '0);
        step();

        // VCSR field write, then field read with a competing hardware write
        instr(NADDR, CSRRW, 32'h3, '0);
        vcsr_addr   = ADDR;
        vcsr_width  = 5'd1;
        vcsr_offset = 5'd2;
        step();
        chk("vcsr_write", data, 8'hC);
        instr(NADDR, CSRRW, 32'h3, '0);
        vcsr_addr        = ADDR;
        ext_write_enable = 1'b1;
        ext_data         = 8'h1;
        #1 chk("vcsr_read_field", csr_out, 32'h3);
        step();
        chk("ext_overrides", data, 8'h1);

        // Timer p=0 C=4
        instr(TADDR, CSRRW, 32'h0000_0004, '0);
        step();
        wait_irq(n);
        chk("timer_first_rise", n, 5);
        interrupt_clear = 1'b1;
        step();
        chk("timer_clear", interrupt_set, 0);
        wait_irq(n);
        chk("timer_rise_to_rise", n + 1, 5);
        instr(TADDR, CSRRW, '0, '0);
        interrupt_clear = 1'b1;
        step();
        repeat (10) step();
        chk("timer_c0_silent", interrupt_set, 0);

        // Match and clear in the same cycle: match wins
        instr(TADDR, CSRRW, 32'h0000_0002, '0);
        step();
        wait_irq(n);
        chk("timer_c2_rise", n, 3);
        for (int i = 0; i < 3; i++) begin
            interrupt_clear = 1'b1;
            step();
        end
        chk("match_beats_clear", interrupt_set, 1);

        // Prescale p=1 C=1: period (C+1)*2^p
        instr(TADDR, CSRRW, 32'h1000_0001, '0);
        interrupt_clear = 1'b1;
        step();
        wait_irq(n);
        chk("timer_prescale", n, 4);
        instr(TADDR, CSRRW, '0, '0);
        interrupt_clear = 1'b1;
        step();

        // Stack
        stack_op(1'b1, 1'b0, 19'h1AAAA);
        stack_op(1'b1, 1'b0, 19'h0BBBB);
        chk("stack_two_index", index_out, 2);
        chk("stack_two_top", stack_out, 19'h0BBBB);
        stack_op(1'b1, 1'b1, 19'h0CCCC);
        chk("stack_replace_index", index_out, 2);
        chk("stack_replace_top", stack_out, 19'h0CCCC);
        repeat (3) stack_op(1'b0, 1'b1, '0);
        chk("stack_empty_index", index_out, 0);
        chk("stack_empty_top", stack_out, 0);
        for (int i = 1; i <= D; i++) stack_op(1'b1, 1'b0, DW'(i * 17));
        stack_op(1'b1, 1'b0, 19'h7FFFF);
        chk("stack_full_index", index_out, D);
        chk("stack_full_top", stack_out, DW'(D * 17));

        // Reset mid-run with depth 3 and a pending timer request
        stack_op(1'b0, 1'b1, '0);
        instr(ADDR, CSRRW, 32'h5A, '0);
        step();
        instr(TADDR, CSRRW, 32'h0000_0001, '0);
        step();
        wait_irq(n);
        chk("pre_reset_irq", interrupt_set, 1);
        chk("pre_reset_index", index_out, 3);
        #1 reset = 1'b0;
        #1;
        chk("midreset_index", index_out, 0);
        chk("midreset_irq", interrupt_set, 0);
        chk("midreset_data", data, 0);
        chk("midreset_stack_out", stack_out, 0);
        step();
        reset = 1'b1;
        step();

        // Randomized traffic
        repeat (3000) begin
            rand_inputs();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
